// File: rtl/rf_wb_scheduler_if.sv
// Register-file write-port scheduling bundle.
// Groups every signal exchanged between the scheduler and its neighbours:
//   WB stage      : wb_wr, wb_addr, wb_data          -> scheduler, wb_hold back
//   LU issue      : lu_iss_valid, lu_iss_addr        -> scheduler, lu_iss_ready back
//   LU result     : lu_res_valid, lu_res_addr/data   -> scheduler, lu_res_ready back
//   ID stage      : id_rs, id_rt, id_rd              -> scheduler, id_stall back
//   RF write port : rf_wr, rf_addr, rf_data          <- scheduler
// Modport slave is taken by the scheduler; modport master by the surrounding pipeline.
interface rf_wb_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              wb_wr;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_hold;

    logic              lu_iss_valid;
    logic [4:0]        lu_iss_addr;
    logic              lu_iss_ready;

    logic              lu_res_valid;
    logic [4:0]        lu_res_addr;
    logic [DATA_W-1:0] lu_res_data;
    logic              lu_res_ready;

    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_stall;

    logic              rf_wr;
    logic [4:0]        rf_addr;
    logic [DATA_W-1:0] rf_data;

    modport slave (
        input  wb_wr, wb_addr, wb_data,
        output wb_hold,
        input  lu_iss_valid, lu_iss_addr,
        output lu_iss_ready,
        input  lu_res_valid, lu_res_addr, lu_res_data,
        output lu_res_ready,
        input  id_rs, id_rt, id_rd,
        output id_stall,
        output rf_wr, rf_addr, rf_data
    );

    modport master (
        output wb_wr, wb_addr, wb_data,
        input  wb_hold,
        output lu_iss_valid, lu_iss_addr,
        input  lu_iss_ready,
        output lu_res_valid, lu_res_addr, lu_res_data,
        input  lu_res_ready,
        output id_rs, id_rt, id_rd,
        input  id_stall,
        input  rf_wr, rf_addr, rf_data
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler and long-latency-unit ownership tracker.
// The WB stage normally owns the single RF write port; long-latency unit (LU)
// results use idle cycles, and after STARVE_LIM consecutive denied cycles the
// LU result is forced through while WB is held for one cycle. A per-register
// busy scoreboard marks destinations of outstanding LU ops and drives the
// ID-stage RAW/WAW stall. No register contents are stored here.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - rf_wb_scheduler_if.slave: WB, LU issue/result, ID query, RF write port
// All bus outputs are combinational from registered state and current inputs.
module rf_wb_scheduler #(
    parameter int DATA_W     = 32,
    parameter int MAX_PEND   = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic               clk,
    input  logic               rst,
    rf_wb_scheduler_if.slave   bus
);
    localparam int PEND_W   = $clog2(MAX_PEND + 1);
    localparam int STARVE_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
    localparam logic [PEND_W-1:0]   PEND_MAX   = PEND_W'(MAX_PEND);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIM - 1);

    typedef enum logic {
        ST_NORM  = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [STARVE_W-1:0] starve_reg;
    logic [STARVE_W-1:0] starve_next;
    logic [PEND_W-1:0]   pend_reg;
    logic [PEND_W-1:0]   pend_next;
    logic [31:1]         busy_reg;
    logic [31:1]         busy_next;
    logic [31:0]         busy_vec;

    logic              wb_claim;
    logic              wb_hold;
    logic              res_ready;
    logic              iss_ready;
    logic              res_acc;
    logic              iss_acc;
    logic              rf_wr;
    logic [4:0]        rf_addr;
    logic [DATA_W-1:0] rf_data;

    // $0 is never owned; bit 0 of the lookup vector is hard-wired clear so
    // the busy lookups need no separate zero-register test.
    assign busy_vec = {busy_reg, 1'b0};

    // A WB write to $0 is a no-op and leaves the port free for the LU.
    assign wb_claim = bus.wb_wr && (bus.wb_addr != 5'd0);

    // Issue sees the registered busy bits only, so an issue to a register
    // whose result retires in the same cycle is refused.
    assign iss_ready = (pend_reg < PEND_MAX) && !busy_vec[bus.lu_iss_addr];
    assign iss_acc   = bus.lu_iss_valid && iss_ready;
    assign res_acc   = bus.lu_res_valid && res_ready;

    // Write-port arbitration and starvation FSM.
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        wb_hold     = 1'b0;
        res_ready   = 1'b0;
        rf_wr       = 1'b0;
        rf_addr     = bus.wb_addr;
        rf_data     = bus.wb_data;

        unique case (state_reg)
            ST_NORM: begin
                if (wb_claim) begin
                    rf_wr = 1'b1;
                    if (bus.lu_res_valid) begin
                        // Result denied; count consecutive losses.
                        if (starve_reg == STARVE_TOP) begin
                            state_next  = ST_FORCE;
                            starve_next = '0;
                        end else begin
                            starve_next = starve_reg + STARVE_W'(1);
                        end
                    end else begin
                        starve_next = '0;
                    end
                end else begin
                    res_ready   = bus.lu_res_valid;
                    rf_addr     = bus.lu_res_addr;
                    rf_data     = bus.lu_res_data;
                    rf_wr       = bus.lu_res_valid && (bus.lu_res_addr != 5'd0);
                    starve_next = '0;
                end
            end
            ST_FORCE: begin
                // WB freezes and re-presents; the starved result takes the port.
                wb_hold     = 1'b1;
                res_ready   = 1'b1;
                rf_addr     = bus.lu_res_addr;
                rf_data     = bus.lu_res_data;
                rf_wr       = bus.lu_res_valid && (bus.lu_res_addr != 5'd0);
                starve_next = '0;
                state_next  = ST_NORM;
            end
            default: begin
                state_next  = ST_NORM;
                starve_next = '0;
            end
        endcase
    end

    // Outstanding-op count. A simultaneous issue and retire cancel out; a
    // retire with nothing outstanding is a protocol error and must not wrap.
    always_comb begin
        pend_next = pend_reg;
        unique case ({iss_acc, res_acc})
            2'b10:   pend_next = pend_reg + PEND_W'(1);
            2'b01:   pend_next = (pend_reg != '0) ? pend_reg - PEND_W'(1) : pend_reg;
            default: pend_next = pend_reg;
        endcase
    end

    // Per-register ownership: issue sets, retire clears, each at its own
    // address. If both hit one register (only possible on a protocol error,
    // since a busy register refuses issue) the new owner wins.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit       = iss_acc && (bus.lu_iss_addr == 5'(gi));
            assign clr_hit       = res_acc && (bus.lu_res_addr == 5'(gi));
            assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_NORM;
            starve_reg <= '0;
            pend_reg   <= '0;
            busy_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            pend_reg   <= pend_next;
            busy_reg   <= busy_next;
        end
    end

    // ID stall uses registered ownership only; a result retiring this cycle
    // is forwarded by the RF itself, not bypassed here.
    assign bus.id_stall     = busy_vec[bus.id_rs] | busy_vec[bus.id_rt] | busy_vec[bus.id_rd];
    assign bus.wb_hold      = wb_hold;
    assign bus.lu_iss_ready = iss_ready;
    assign bus.lu_res_ready = res_ready;
    assign bus.rf_wr        = rf_wr;
    assign bus.rf_addr      = rf_addr;
    assign bus.rf_data      = rf_data;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed-vector bench for rf_wb_scheduler (DATA_W=32, MAX_PEND=4, STARVE_LIM=3).
// The driver applies one vector per cycle and queues the hand-computed
// expected outputs; a monitor on the falling edge pops and compares them, and
// separately matches every RF write the DUT presents against a write queue.
module tb_rf_wb_scheduler;
    localparam int DATA_W = 32;

    typedef struct {
        string       name;
        int          hold;
        int          iss_rdy;
        int          res_rdy;
        int          stall;
        int          wr;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    typedef struct {
        string       name;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    always #5 clk = ~clk;

    rf_wb_scheduler_if #(.DATA_W(DATA_W)) bus ();

    rf_wb_scheduler #(
        .DATA_W(DATA_W),
        .MAX_PEND(4),
        .STARVE_LIM(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // One vector: inputs, then expected hold/iss_ready/res_ready/stall/rf_wr
    // (-1 = not checked) and the expected write address/data when rf_wr=1.
    task automatic cyc(input string name, input logic r,
                       input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic iv, input logic [4:0] ia,
                       input logic rv, input logic [4:0] ra, input logic [31:0] rd_data,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input int e_hold, input int e_irdy, input int e_rrdy, input int e_stall,
                       input int e_wr, input logic [4:0] e_wa, input logic [31:0] e_wd);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.wb_wr        = wbw;
        bus.wb_addr      = wba;
        bus.wb_data      = wbd;
        bus.lu_iss_valid = iv;
        bus.lu_iss_addr  = ia;
        bus.lu_res_valid = rv;
        bus.lu_res_addr  = ra;
        bus.lu_res_data  = rd_data;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        e.name    = name;
        e.hold    = e_hold;
        e.iss_rdy = e_irdy;
        e.res_rdy = e_rrdy;
        e.stall   = e_stall;
        e.wr      = e_wr;
        e.wa      = e_wa;
        e.wd      = e_wd;
        exp_q.push_back(e);
        if (e_wr == 1) wr_q.push_back('{name, e_wa, e_wd});
    endtask

    task automatic chk_bit(input string name, input string field, input int expv, input logic act);
        if (expv >= 0) begin
            checks++;
            if (act !== expv[0]) begin
                failures++;
                $display("FAIL %s.%s actual=%b required=%0d", name, field, act, expv);
            end
        end
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (bus.rf_wr === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%0d data=%h required=no write",
                             bus.rf_addr, bus.rf_data);
                end else begin
                    w = wr_q.pop_front();
                    checks++;
                    if (bus.rf_addr !== w.wa) begin
                        failures++;
                        $display("FAIL %s.rf_addr actual=%0d required=%0d", w.name, bus.rf_addr, w.wa);
                    end
                    checks++;
                    if (bus.rf_data !== w.wd) begin
                        failures++;
                        $display("FAIL %s.rf_data actual=%h required=%h", w.name, bus.rf_data, w.wd);
                    end
                end
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d %s: rf_wr=%b rf_addr=%0d rf_data=%h wb_hold=%b iss_rdy=%b res_rdy=%b id_stall=%b",
                         txn, e.name, bus.rf_wr, bus.rf_addr, bus.rf_data, bus.wb_hold,
                         bus.lu_iss_ready, bus.lu_res_ready, bus.id_stall);
                chk_bit(e.name, "wb_hold",      e.hold,    bus.wb_hold);
                chk_bit(e.name, "lu_iss_ready", e.iss_rdy, bus.lu_iss_ready);
                chk_bit(e.name, "lu_res_ready", e.res_rdy, bus.lu_res_ready);
                chk_bit(e.name, "id_stall",     e.stall,   bus.id_stall);
                chk_bit(e.name, "rf_wr",        e.wr,      bus.rf_wr);
            end
        end
    end

    // Watchdog: the run is a fixed handful of cycles.
    initial begin
        #100000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.wb_wr        = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        bus.lu_iss_valid = 1'b0;
        bus.lu_iss_addr  = '0;
        bus.lu_res_valid = 1'b0;
        bus.lu_res_addr  = '0;
        bus.lu_res_data  = '0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_rd        = '0;

        //   name          rst wbw wba wbd         iv ia rv ra rdata        rs rt rd   hold irdy rrdy stall wr wa wd
        cyc("reset_a",     1, 0, 0,  32'h0,       0, 0, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("reset_b",     1, 0, 0,  32'h0,       0, 0, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("wb_write",    0, 1, 5,  32'h11,      0, 0, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 1, 5,  32'h11);
        // Ownership of $8 and the RAW stall it causes.
        cyc("issue8",      0, 0, 0,  32'h0,       1, 8, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("raw_stall",   0, 0, 0,  32'h0,       0, 8, 0, 0, 32'h0,       8, 0, 0,   0, 0, 0, 1, 0, 0,  32'h0);
        cyc("res8",        0, 0, 0,  32'h0,       0, 0, 1, 8, 32'hABCD,    8, 0, 0,   0, 1, 1, 1, 1, 8,  32'hABCD);
        cyc("stall_clr",   0, 0, 0,  32'h0,       0, 0, 0, 0, 32'h0,       8, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        // Fill to MAX_PEND, refuse the fifth, free a slot.
        cyc("iss1",        0, 0, 0,  32'h0,       1, 1, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("iss2",        0, 0, 0,  32'h0,       1, 2, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("iss3",        0, 0, 0,  32'h0,       1, 3, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("iss4",        0, 0, 0,  32'h0,       1, 4, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("iss6_full",   0, 0, 0,  32'h0,       1, 6, 0, 0, 32'h0,       0, 0, 0,   0, 0, 0, 0, 0, 0,  32'h0);
        cyc("res1_full",   0, 0, 0,  32'h0,       1, 6, 1, 1, 32'h100,     0, 0, 0,   0, 0, 1, 0, 1, 1,  32'h100);
        cyc("iss6_ok",     0, 0, 0,  32'h0,       1, 6, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        // Starvation: three denied cycles, then a forced LU write with WB held.
        cyc("starve1",     0, 1, 10, 32'hA0,      0, 0, 1, 2, 32'h200,     0, 0, 0,   0, 0, 0, 0, 1, 10, 32'hA0);
        cyc("starve2",     0, 1, 11, 32'hA1,      0, 0, 1, 2, 32'h200,     0, 0, 0,   0, 0, 0, 0, 1, 11, 32'hA1);
        cyc("starve3",     0, 1, 12, 32'hA2,      0, 0, 1, 2, 32'h200,     0, 0, 0,   0, 0, 0, 0, 1, 12, 32'hA2);
        cyc("force",       0, 1, 13, 32'hA3,      0, 0, 1, 2, 32'h200,     0, 0, 0,   1, 0, 1, 0, 1, 2,  32'h200);
        cyc("wb_replay",   0, 1, 13, 32'hA3,      0, 0, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 1, 13, 32'hA3);
        // Same-cycle issue and retire on different registers.
        cyc("iss9_res3",   0, 0, 0,  32'h0,       1, 9, 1, 3, 32'h300,     0, 0, 3,   0, 1, 1, 1, 1, 3,  32'h300);
        cyc("stall9",      0, 0, 0,  32'h0,       0, 0, 0, 0, 32'h0,       9, 3, 0,   0, 1, 0, 1, 0, 0,  32'h0);
        // Issue to the register retiring this cycle is refused.
        cyc("iss4_res4",   0, 0, 0,  32'h0,       1, 4, 1, 4, 32'h400,     3, 0, 0,   0, 0, 1, 0, 1, 4,  32'h400);
        cyc("iss4_again",  0, 0, 0,  32'h0,       1, 4, 0, 0, 32'h0,       4, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        // $0 ownership: counted but never busy, never written; WB to $0 frees the port.
        cyc("iss_zero",    0, 0, 0,  32'h0,       1, 0, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        cyc("res_zero",    0, 1, 0,  32'hDEAD,    0, 0, 1, 0, 32'h55,      0, 0, 0,   0, 0, 1, 0, 0, 0,  32'h0);
        cyc("zero_free",   0, 0, 0,  32'h0,       0, 0, 0, 0, 32'h0,       0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);
        // Starve again and reset during the forced cycle.
        cyc("starve_b1",   0, 1, 14, 32'hB0,      0, 0, 1, 6, 32'h600,     0, 0, 0,   0, 1, 0, 0, 1, 14, 32'hB0);
        cyc("starve_b2",   0, 1, 15, 32'hB1,      0, 0, 1, 6, 32'h600,     0, 0, 0,   0, 1, 0, 0, 1, 15, 32'hB1);
        cyc("starve_b3",   0, 1, 16, 32'hB2,      0, 0, 1, 6, 32'h600,     0, 0, 0,   0, 1, 0, 0, 1, 16, 32'hB2);
        cyc("force_rst",   1, 1, 17, 32'hB3,      0, 0, 1, 6, 32'h600,     0, 0, 0,   1, 1, 1, 0, 1, 6,  32'h600);
        cyc("after_rst",   0, 1, 17, 32'hB3,      0, 4, 0, 0, 32'h0,       4, 9, 6,   0, 1, 0, 0, 1, 17, 32'hB3);
        cyc("post_rst_9",  0, 0, 0,  32'h0,       0, 9, 0, 0, 32'h0,       9, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d writes,%0d vectors left required=0,0", wr_q.size(), exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
